sh_ibus_fabric: RTL and testbench

Parametrised internal-bus interconnect for SH-family SoC tops. It replaces the fixed priority read-data mux and single-wait wiring between the cache/IBUS master and the on-chip peripherals (INTC, FRT, WDT, SCI, DIVU, DMAC, BSC). It provides address-window decode over NSLV slaves, per-access ready handshake, timeout/error response, lock, and an external bus-release grant handshake.

---
 rtl/sh_pkg.sv | 27 ++
 rtl/sh_ibus_fabric_if.sv | 50 +++++
 rtl/sh_ibus_decode.sv | 40 ++++
 rtl/sh_ibus_fabric.sv | 109 ++++++++++
 tb/tb_sh_ibus_fabric.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sh_pkg.sv
// Shared SH internal-bus types and helpers: FSM state encoding, one-hot select
// and address window compare.
package sh_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR,
    REL
  } IbusState_t;

  localparam int SH_MAX_SLV = 16;
  localparam int SH_MAX_AW  = 64;

  // Bit n of the one-hot code for idx; callers build a select vector bit by bit
  function automatic logic onehot(input logic [3:0] idx, input int n);
    return (int'(idx) == n);
  endfunction

  function automatic logic win_hit(input logic [SH_MAX_AW-1:0] a,
                                   input logic [SH_MAX_AW-1:0] base,
                                   input logic [SH_MAX_AW-1:0] mask);
    return ((a & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/sh_ibus_fabric_if.sv
// SH internal-bus signal bundle: master side, broadcast slave side and the
// external bus-release handshake.
interface sh_ibus_fabric_if #(
  parameter int NSLV = 8,
  parameter int AW   = 32,
  parameter int DW   = 32,
  localparam int BW  = DW / 8
);
  logic [AW-1:0]      M_A;
  logic [DW-1:0]      M_DI;
  logic [DW-1:0]      M_DO;
  logic [BW-1:0]      M_BA;
  logic               M_WE;
  logic               M_REQ;
  logic               M_LOCK;
  logic               M_BUSY;
  logic               M_ERR;
  logic [NSLV-1:0]    S_SEL;
  logic [AW-1:0]      S_A;
  logic [DW-1:0]      S_DO;
  logic [BW-1:0]      S_BA;
  logic               S_WE;
  logic               S_REQ;
  logic [NSLV*DW-1:0] S_DI;
  logic [NSLV-1:0]    S_ACK;
  logic               BREQ_N;
  logic               BACK_N;
  logic               RLS;

  modport fabric (
    input  M_A, M_DI, M_BA, M_WE, M_REQ, M_LOCK, S_DI, S_ACK, BREQ_N,
    output M_DO, M_BUSY, M_ERR, S_SEL, S_A, S_DO, S_BA, S_WE, S_REQ, BACK_N, RLS
  );

  modport master (
    output M_A, M_DI, M_BA, M_WE, M_REQ, M_LOCK,
    input  M_DO, M_BUSY, M_ERR
  );

  modport slave (
    input  S_SEL, S_A, S_DO, S_BA, S_WE, S_REQ,
    output S_DI, S_ACK
  );

  modport ext (
    output BREQ_N,
    input  BACK_N, RLS
  );

endinterface

// File: rtl/sh_ibus_decode.sv
// Combinational address-window decoder: per-slave hit vector, any-hit flag and
// lowest hitting index (lowest index wins on overlapping windows).
module sh_ibus_decode
  import sh_pkg::*;
#(
  parameter int                 NSLV     = 8,
  parameter int                 AW       = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  localparam int                IW       = (NSLV > 1) ? $clog2(NSLV) : 1
) (
  input  logic [AW-1:0]   addr,
  output logic [NSLV-1:0] hit,
  output logic            any_hit,
  output logic [IW-1:0]   low_idx
);

  always_comb begin
    logic [SH_MAX_AW-1:0] a_ext;
    logic [SH_MAX_AW-1:0] b_ext;
    logic [SH_MAX_AW-1:0] m_ext;
    hit     = '0;
    low_idx = '0;
    a_ext   = '0;
    b_ext   = '0;
    m_ext   = '0;
    a_ext[AW-1:0] = addr;
    for (int i = 0; i < NSLV; i++) begin
      b_ext[AW-1:0] = SLV_BASE[i*AW +: AW];
      m_ext[AW-1:0] = SLV_MASK[i*AW +: AW];
      hit[i] = win_hit(a_ext, b_ext, m_ext);
    end
    // Descending scan so the lowest hitting index is written last
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (hit[i]) low_idx = IW'(i);
    end
    any_hit = |hit;
  end

endmodule

// File: rtl/sh_ibus_fabric.sv
// SH internal-bus interconnect: window decode over NSLV slaves, ready handshake,
// timeout/error completion, lock and external bus-release grant.
module sh_ibus_fabric
  import sh_pkg::*;
#(
  parameter int                 NSLV     = 8,
  parameter int                 AW       = 32,
  parameter int                 DW       = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '0,
  parameter int                 TO_CYC   = 255
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           CE_R,
  sh_ibus_fabric_if.fabric bus
);

  localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = $clog2(TO_CYC + 1);

  IbusState_t      state, state_nx;
  logic [IW-1:0]   sel_q;
  logic [IW-1:0]   dec_idx;
  logic [NSLV-1:0] dec_hit;
  logic            dec_any;
  logic [CW-1:0]   to_cnt;
  logic            req_hit, req_miss, ack_sel, to_hit;

  sh_ibus_decode #(
    .NSLV     (NSLV),
    .AW       (AW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr    (bus.M_A),
    .hit     (dec_hit),
    .any_hit (dec_any),
    .low_idx (dec_idx)
  );

  assign req_hit  = bus.M_REQ && dec_any;
  assign req_miss = bus.M_REQ && (dec_hit == '0);
  assign ack_sel  = bus.S_ACK[sel_q];
  assign to_hit   = (to_cnt == CW'(TO_CYC - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)    state <= IDLE;
    else if (CE_R) state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.M_BUSY  = bus.M_REQ && (state != DONE) && (state != ERR);
    bus.M_ERR   = (state == ERR);
    bus.S_REQ   = (state == ACCESS);
    bus.BACK_N  = (state != REL);
    bus.RLS     = (state == REL);
    for (int i = 0; i < NSLV; i++) begin
      bus.S_SEL[i] = (state == ACCESS) && onehot(4'(sel_q), i);
    end
    unique case (state)
      IDLE: begin
        // Release has priority over a pending access unless the master holds lock
        if (!bus.BREQ_N && !bus.M_LOCK) state_nx = REL;
        else if (req_hit)               state_nx = ACCESS;
        else if (req_miss)              state_nx = ERR;
      end
      ACCESS: begin
        if (ack_sel)     state_nx = DONE;
        else if (to_hit) state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      REL:     if (bus.BREQ_N) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Access capture at ACCESS entry, timeout count and read-data return
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_q    <= '0;
      to_cnt   <= '0;
      bus.M_DO <= '0;
      bus.S_A  <= '0;
      bus.S_DO <= '0;
      bus.S_BA <= '0;
      bus.S_WE <= 1'b0;
    end else if (CE_R) begin
      if (state == IDLE && state_nx == ACCESS) begin
        sel_q    <= dec_idx;
        to_cnt   <= '0;
        bus.S_A  <= bus.M_A;
        bus.S_DO <= bus.M_DI;
        bus.S_BA <= bus.M_BA;
        bus.S_WE <= bus.M_WE;
      end else if (state == ACCESS && to_cnt != CW'(TO_CYC)) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (state == ACCESS && ack_sel && !bus.S_WE) begin
        bus.M_DO <= bus.S_DI[sel_q*DW +: DW];
      end else if (state_nx == ERR) begin
        bus.M_DO <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sh_ibus_fabric.sv
// Directed scoreboard bench for sh_ibus_fabric: 4 slaves, 16-cycle timeout.
module tb_sh_ibus_fabric;
  localparam int NSLV   = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int TO_CYC = 16;
  localparam logic [NSLV*AW-1:0] BASES =
    {32'hFFFFFE00, 32'hFFFFFE00, 32'hFFFFFC00, 32'hA0000000};
  localparam logic [NSLV*AW-1:0] MASKS =
    {32'hFFFFFE00, 32'hFFFFFF00, 32'hFFFFFF00, 32'hFF000000};

  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          lat;
    int          reqs;
    logic [3:0]  sel;
  } exp_t;

  logic CLK, RST_N, CE_R;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];
  logic [31:0] cap_sdo;
  logic [3:0]  cap_sba;
  logic        cap_swe;
  logic        grant_during;

  sh_ibus_fabric_if #(.NSLV(NSLV), .AW(AW), .DW(DW)) bus ();

  sh_ibus_fabric #(
    .NSLV(NSLV), .AW(AW), .DW(DW),
    .SLV_BASE(BASES), .SLV_MASK(MASKS), .TO_CYC(TO_CYC)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE_R  (CE_R),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_sdi(input int slv, input logic [31:0] rdata);
    for (int i = 0; i < NSLV; i++)
      bus.S_DI[i*DW +: DW] = (i == slv) ? rdata : (32'hDEAD0000 | 32'(i));
  endtask

  // Drives one request, plays the addressed slave (ack after ack_wait waits,
  // never if negative), then pops the scoreboard at completion.
  task automatic run_access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic we, input logic [3:0] ba, input int slv,
                            input int ack_wait, input logic [31:0] rdata,
                            input int breq_cyc, input exp_t e);
    exp_t got;
    int   cyc = 0;
    int   acc = 0;
    bit   done = 0;
    logic [3:0] sel_seen = '0;
    sb_q.push_back(e);
    grant_during = 1'b0;
    @(negedge CLK);
    bus.M_A = addr; bus.M_DI = wdata; bus.M_WE = we; bus.M_BA = ba; bus.M_REQ = 1'b1;
    set_sdi(slv, rdata);
    bus.S_ACK = '0;
    while (!done && cyc < 64) begin
      @(negedge CLK);
      cyc++;
      if (!bus.BACK_N) grant_during = 1'b1;
      if (!bus.M_BUSY) begin
        done = 1;
      end else if (bus.S_REQ) begin
        acc++;
        if (acc == 1) sel_seen = bus.S_SEL;
        cap_sdo = bus.S_DO; cap_sba = bus.S_BA; cap_swe = bus.S_WE;
        bus.S_ACK = (ack_wait >= 0 && acc == ack_wait + 1) ? 4'(1 << slv) : 4'b0;
      end
      if (cyc == breq_cyc) bus.BREQ_N = 1'b0;
    end
    bus.S_ACK = '0;
    bus.M_REQ = 1'b0;
    chk({tag, "_completed"}, 64'(done), 64'd1);
    got = sb_q.pop_front();
    chk({tag, "_m_do"},  64'(bus.M_DO), 64'(got.dout));
    chk({tag, "_m_err"}, 64'(bus.M_ERR), 64'(got.err));
    chk({tag, "_lat"},   64'(cyc), 64'(got.lat));
    chk({tag, "_s_req_cycles"}, 64'(acc), 64'(got.reqs));
    chk({tag, "_s_sel"}, 64'(sel_seen), 64'(got.sel));
  endtask

  initial begin
    exp_t e;
    RST_N = 1'b1; CE_R = 1'b1;
    bus.M_A = '0; bus.M_DI = '0; bus.M_BA = '0; bus.M_WE = 1'b0;
    bus.M_REQ = 1'b0; bus.M_LOCK = 1'b0; bus.BREQ_N = 1'b1;
    bus.S_DI = '0; bus.S_ACK = '0;
    #1 RST_N = 1'b0;
    @(negedge CLK);
    chk("rst_m_do", 64'(bus.M_DO), 64'd0);
    chk("rst_m_err", 64'(bus.M_ERR), 64'd0);
    chk("rst_s_sel", 64'(bus.S_SEL), 64'd0);
    chk("rst_s_req", 64'(bus.S_REQ), 64'd0);
    chk("rst_back_n", 64'(bus.BACK_N), 64'd1);
    chk("rst_rls", 64'(bus.RLS), 64'd0);
    chk("rst_m_busy", 64'(bus.M_BUSY), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Clock enable low: request must not be taken
    CE_R = 1'b0;
    bus.M_A = 32'hFFFFFE10; bus.M_REQ = 1'b1;
    @(negedge CLK); @(negedge CLK);
    chk("ce_freeze_busy", 64'(bus.M_BUSY), 64'd1);
    chk("ce_freeze_s_req", 64'(bus.S_REQ), 64'd0);
    bus.M_REQ = 1'b0; CE_R = 1'b1;

    // Zero-wait read, overlap of slaves 2 and 3 resolves to 2
    e = '{dout: 32'h12345678, err: 1'b0, lat: 2, reqs: 1, sel: 4'b0100};
    run_access("rd_s2", 32'hFFFFFE10, 32'h0, 1'b0, 4'hF, 2, 0, 32'h12345678, -1, e);

    // Write with 5 wait cycles; read data must stay from the previous read
    e = '{dout: 32'h12345678, err: 1'b0, lat: 7, reqs: 6, sel: 4'b0010};
    run_access("wr_s1", 32'hFFFFFC04, 32'hA5A5A5A5, 1'b1, 4'b0011, 1, 5, 32'h11112222, -1, e);
    chk("wr_s1_s_do", 64'(cap_sdo), 64'h A5A5A5A5);
    chk("wr_s1_s_ba", 64'(cap_sba), 64'b0011);
    chk("wr_s1_s_we", 64'(cap_swe), 64'd1);

    // Unmapped address
    e = '{dout: 32'h0, err: 1'b1, lat: 1, reqs: 0, sel: 4'b0000};
    run_access("unmapped", 32'h00001000, 32'h0, 1'b0, 4'hF, 0, -1, 32'h99999999, -1, e);

    // Slave never acks: timeout after TO_CYC access cycles
    e = '{dout: 32'h0, err: 1'b1, lat: TO_CYC + 1, reqs: TO_CYC, sel: 4'b0001};
    run_access("timeout", 32'hA0000040, 32'h0, 1'b0, 4'hF, 0, -1, 32'h77777777, -1, e);

    // Normal access after timeout
    e = '{dout: 32'h0BADBEEF, err: 1'b0, lat: 3, reqs: 2, sel: 4'b1000};
    run_access("rd_s3", 32'hFFFFFF00, 32'h0, 1'b0, 4'hF, 3, 1, 32'h0BADBEEF, -1, e);

    // Bus request raised mid-access: grant withheld until after DONE
    e = '{dout: 32'hCAFEF00D, err: 1'b0, lat: 4, reqs: 3, sel: 4'b0100};
    run_access("rd_breq", 32'hFFFFFE20, 32'h0, 1'b0, 4'hF, 2, 2, 32'hCAFEF00D, 1, e);
    chk("no_grant_in_access", 64'(grant_during), 64'd0);
    @(negedge CLK);
    chk("idle_back_n", 64'(bus.BACK_N), 64'd1);
    @(negedge CLK);
    chk("rel_back_n", 64'(bus.BACK_N), 64'd0);
    chk("rel_rls", 64'(bus.RLS), 64'd1);

    // Request during release stalls, then proceeds once BREQ_N returns high
    bus.M_A = 32'hFFFFFE30; bus.M_WE = 1'b0; bus.M_REQ = 1'b1;
    set_sdi(2, 32'h600DCAFE);
    sb_q.push_back('{dout: 32'h600DCAFE, err: 1'b0, lat: 0, reqs: 1, sel: 4'b0100});
    @(negedge CLK);
    chk("rel_busy", 64'(bus.M_BUSY), 64'd1);
    chk("rel_s_req", 64'(bus.S_REQ), 64'd0);
    @(negedge CLK);
    chk("rel_busy2", 64'(bus.M_BUSY), 64'd1);
    bus.BREQ_N = 1'b1;
    @(negedge CLK);
    chk("unrel_rls", 64'(bus.RLS), 64'd0);
    chk("unrel_back_n", 64'(bus.BACK_N), 64'd1);
    chk("unrel_busy", 64'(bus.M_BUSY), 64'd1);
    @(negedge CLK);
    chk("post_rel_s_req", 64'(bus.S_REQ), 64'd1);
    chk("post_rel_s_sel", 64'(bus.S_SEL), 64'(sb_q[0].sel));
    bus.S_ACK = 4'b0100;
    @(negedge CLK);
    e = sb_q.pop_front();
    chk("post_rel_m_do", 64'(bus.M_DO), 64'(e.dout));
    chk("post_rel_m_err", 64'(bus.M_ERR), 64'(e.err));
    chk("post_rel_busy", 64'(bus.M_BUSY), 64'd0);
    bus.S_ACK = '0; bus.M_REQ = 1'b0;

    // Lock blocks the grant; dropping it grants one cycle later
    @(negedge CLK);
    bus.M_LOCK = 1'b1; bus.BREQ_N = 1'b0;
    @(negedge CLK); @(negedge CLK);
    chk("lock_back_n", 64'(bus.BACK_N), 64'd1);
    chk("lock_rls", 64'(bus.RLS), 64'd0);
    bus.M_LOCK = 1'b0;
    @(negedge CLK);
    chk("unlock_back_n", 64'(bus.BACK_N), 64'd0);
    chk("unlock_rls", 64'(bus.RLS), 64'd1);

    // Asynchronous reset during release drops the grant at once
    #2 RST_N = 1'b0;
    #1;
    chk("rst_rel_back_n", 64'(bus.BACK_N), 64'd1);
    chk("rst_rel_rls", 64'(bus.RLS), 64'd0);
    @(negedge CLK);
    RST_N = 1'b1; bus.BREQ_N = 1'b1;
    @(negedge CLK);
    chk("after_rst_back_n", 64'(bus.BACK_N), 64'd1);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
